// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo
// Description : UART serial-in/parallel-out receiver. Oversampled start-bit
//               detection and validation, 7/8 data bits LSB first, optional
//               odd/even parity check, and 1/2 stop bits with error flags.
//               Frame options are latched at start detect.
//               Optional macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote
//               of the samples around the bit centre instead of one sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sipo #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       sample_tick,
    input  logic       data_tx,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_parallel,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       rx_active,
    output logic       rx_done
);

    localparam int TW = $clog2(OVERSAMPLE);

    // Last tick of a bit period: data/parity/stop samples are OVERSAMPLE ticks apart.
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the centre, so the decision lands one tick later.
    localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] TICK_START = TW'(OVERSAMPLE / 2 - 1);
`endif

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [3:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_acc_q, par_acc_d;
    logic                   perr_next_q, perr_next_d;
    logic                   serr_next_q, serr_next_d;
    logic                   armed_q, armed_d;
    logic                   par_en_q, par_en_d;
    logic                   par_odd_q, par_odd_d;
    logic                   stop2_q, stop2_d;
    logic                   len8_q, len8_d;
    logic [7:0]             data_parallel_q, data_parallel_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   parity_error_q, parity_error_d;
    logic                   stop_error_q, stop_error_d;
    logic                   rx_active_q, rx_active_d;
    logic                   rx_done_q, rx_done_d;

    logic                   w_rx_s;
    logic                   w_bit;
    logic                   w_bit_end;
    logic [7:0]             w_word;

    // Input synchronizer chain; the FSM only ever sees the last stage.
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], data_tx};
    assign w_rx_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    // History of the two previous tick samples feeding the 2-of-3 vote.
    always_comb hist_d = sample_tick ? {hist_q[0], w_rx_s} : hist_q;

    // History register, idle-high after reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) hist_q <= 2'b11;
        else      hist_q <= hist_d;
    end

    assign w_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & w_rx_s) | (hist_q[0] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    assign w_bit_end = sample_tick && (tick_q == TICK_LAST);
    // In 7-bit mode only seven shifts happen, so the word sits in [7:1].
    assign w_word    = len8_q ? shift_q : {1'b0, shift_q[7:1]};

    // Receive FSM and all next-state/output computation.
    always_comb begin
        state_d         = state_q;
        tick_d          = tick_q;
        bit_d           = bit_q;
        shift_d         = shift_q;
        par_acc_d       = par_acc_q;
        perr_next_d     = perr_next_q;
        serr_next_d     = serr_next_q;
        armed_d         = armed_q;
        par_en_d        = par_en_q;
        par_odd_d       = par_odd_q;
        stop2_d         = stop2_q;
        len8_d          = len8_q;
        data_parallel_d = data_parallel_q;
        rx_valid_d      = 1'b0;
        parity_error_d  = parity_error_q;
        stop_error_d    = stop_error_q;
        rx_active_d     = rx_active_q;
        rx_done_d       = rx_done_q;

        case (state_q)
            S_IDLE: begin
                // A start is only a falling edge seen after the line was high.
                if (w_rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d     = S_START;
                    armed_d     = 1'b0;
                    tick_d      = '0;
                    bit_d       = '0;
                    shift_d     = '0;
                    par_acc_d   = 1'b0;
                    perr_next_d = 1'b0;
                    serr_next_d = 1'b0;
                    par_en_d    = (parity_type == 2'b01) || (parity_type == 2'b10);
                    par_odd_d   = (parity_type == 2'b01);
                    stop2_d     = stop_bits;
                    len8_d      = data_length;
                    rx_active_d = 1'b1;
                    rx_done_d   = 1'b0;
                end
            end
            S_START: begin
                if (sample_tick) begin
                    if (tick_q == TICK_START) begin
                        tick_d = '0;
                        if (w_bit) begin
                            state_d     = S_IDLE;
                            rx_active_d = 1'b0;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (w_bit_end) begin
                    tick_d = '0;
                    if (state_q == S_DATA) begin
                        shift_d   = {w_bit, shift_q[7:1]};
                        par_acc_d = par_acc_q ^ w_bit;
                        bit_d     = bit_q + 1'b1;
                        if (bit_q == (len8_q ? 4'd7 : 4'd6)) begin
                            bit_d   = '0;
                            state_d = par_en_q ? S_PARITY : S_STOP;
                        end
                    end else if (state_q == S_PARITY) begin
                        // Even: XOR must be 0; odd: XOR must be 1.
                        perr_next_d = par_acc_q ^ w_bit ^ par_odd_q;
                        state_d     = S_STOP;
                    end else begin
                        if (!w_bit) serr_next_d = 1'b1;
                        bit_d = bit_q + 1'b1;
                        if (bit_q == (stop2_q ? 4'd1 : 4'd0)) begin
                            state_d = S_DONE;
                            // A low final stop (break) must see the line high before re-arming.
                            armed_d = w_bit;
                        end
                    end
                end else if (sample_tick) begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_DONE: begin
                data_parallel_d = w_word;
                parity_error_d  = perr_next_q;
                stop_error_d    = serr_next_q;
                rx_valid_d      = 1'b1;
                rx_done_d       = 1'b1;
                rx_active_d     = 1'b0;
                armed_d         = armed_q | w_rx_s;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            sync_q          <= '1;
            state_q         <= S_IDLE;
            tick_q          <= '0;
            bit_q           <= '0;
            shift_q         <= '0;
            par_acc_q       <= 1'b0;
            perr_next_q     <= 1'b0;
            serr_next_q     <= 1'b0;
            armed_q         <= 1'b0;
            par_en_q        <= 1'b0;
            par_odd_q       <= 1'b0;
            stop2_q         <= 1'b0;
            len8_q          <= 1'b0;
            data_parallel_q <= '0;
            rx_valid_q      <= 1'b0;
            parity_error_q  <= 1'b0;
            stop_error_q    <= 1'b0;
            rx_active_q     <= 1'b0;
            rx_done_q       <= 1'b0;
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            tick_q          <= tick_d;
            bit_q           <= bit_d;
            shift_q         <= shift_d;
            par_acc_q       <= par_acc_d;
            perr_next_q     <= perr_next_d;
            serr_next_q     <= serr_next_d;
            armed_q         <= armed_d;
            par_en_q        <= par_en_d;
            par_odd_q       <= par_odd_d;
            stop2_q         <= stop2_d;
            len8_q          <= len8_d;
            data_parallel_q <= data_parallel_d;
            rx_valid_q      <= rx_valid_d;
            parity_error_q  <= parity_error_d;
            stop_error_q    <= stop_error_d;
            rx_active_q     <= rx_active_d;
            rx_done_q       <= rx_done_d;
        end
    end

    assign data_parallel = data_parallel_q;
    assign rx_valid      = rx_valid_q;
    assign parity_error  = parity_error_q;
    assign stop_error    = stop_error_q;
    assign rx_active     = rx_active_q;
    assign rx_done       = rx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sipo
// Description : Self-checking bench for uart_rx_sipo. Directed frames, reset,
//               false start, line break and randomized frames compared with
//               a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;

    localparam int OVERSAMPLE = 16;
    localparam int TDIV       = 2;
    localparam int BITCLK     = OVERSAMPLE * TDIV;

    logic       clock       = 1'b0;
    logic       rst         = 1'b1;
    logic       sample_tick = 1'b0;
    logic       data_tx     = 1'b1;
    logic [1:0] parity_type = 2'b00;
    logic       stop_bits   = 1'b0;
    logic       data_length = 1'b1;
    logic [7:0] data_parallel;
    logic       rx_valid;
    logic       parity_error;
    logic       stop_error;
    logic       rx_active;
    logic       rx_done;

    int         n_vec      = 0;
    int         n_err      = 0;
    int         pulse_cnt  = 0;
    int         exp_frames = 0;
    int         tdiv_cnt   = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] cap_data   = 8'h00;
    logic       cap_perr   = 1'b0;
    logic       cap_serr   = 1'b0;
    logic       cap_done   = 1'b0;
    logic       cap_active = 1'b0;
    logic [7:0] last_data  = 8'h00;

    uart_rx_sipo #(
        .OVERSAMPLE (OVERSAMPLE),
        .SYNC_STAGES(2)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .data_tx      (data_tx),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_parallel(data_parallel),
        .rx_valid     (rx_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .rx_active    (rx_active),
        .rx_done      (rx_done)
    );

    always #5 clock = ~clock;

    // Baud-generator stand-in: one tick every TDIV clocks.
    always @(negedge clock) begin
        tdiv_cnt    = (tdiv_cnt == TDIV - 1) ? 0 : tdiv_cnt + 1;
        sample_tick = (tdiv_cnt == 0);
    end

    // Capture each rx_valid pulse and check it is a single clock wide.
    always @(negedge clock) begin
        if (rx_valid === 1'b1) begin
            n_vec++;
            assert (prev_valid === 1'b0) else begin
                n_err++;
                $error("FAIL rx_valid_width: observed 2+ cycles expected 1 cycle");
            end
            pulse_cnt++;
            cap_data   = data_parallel;
            cap_perr   = parity_error;
            cap_serr   = stop_error;
            cap_done   = rx_done;
            cap_active = rx_active;
        end
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_tx = b;
        repeat (BITCLK) @(negedge clock);
    endtask

    task automatic idle_bits(input int n);
        data_tx = 1'b1;
        repeat (n * BITCLK) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic len8, input logic [1:0] pt,
                              input logic st2, input logic pb, input logic s0, input logic s1);
        data_length = len8;
        parity_type = pt;
        stop_bits   = st2;
        send_bit(1'b0);
        for (int i = 0; i < (len8 ? 8 : 7); i++) send_bit(d[i]);
        if (pt == 2'b01 || pt == 2'b10) send_bit(pb);
        send_bit(s0);
        if (st2) send_bit(s1);
        data_tx = 1'b1;
    endtask

    // Reference model: frame-level expectations from the frame contents.
    task automatic check_frame(input string tag, input logic [7:0] d, input logic len8,
                               input logic [1:0] pt, input logic pb, input logic st2,
                               input logic s0, input logic s1);
        logic [7:0] exp_d;
        int         ones;
        logic       exp_perr;
        logic       exp_serr;
        exp_frames++;
        for (int i = 0; i < 4 * BITCLK; i++) begin
            if (pulse_cnt >= exp_frames) break;
            @(negedge clock);
        end
        exp_d = len8 ? d : (d & 8'h7F);
        ones  = $countones(exp_d) + int'(pb);
        if (pt == 2'b10)      exp_perr = (ones % 2) != 0;
        else if (pt == 2'b01) exp_perr = (ones % 2) != 1;
        else                  exp_perr = 1'b0;
        exp_serr  = !s0 || (st2 && !s1);
        last_data = exp_d;
        check({tag, "_pulses"}, pulse_cnt, exp_frames);
        check({tag, "_data"},   {24'h0, cap_data}, {24'h0, exp_d});
        check({tag, "_perr"},   {31'h0, cap_perr}, {31'h0, exp_perr});
        check({tag, "_serr"},   {31'h0, cap_serr}, {31'h0, exp_serr});
        check({tag, "_done"},   {30'h0, cap_done, cap_active}, 32'h2);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  d;
        logic        len8, st2, pb, corr, s0, s1;
        logic [1:0]  pt;

        // Reset state
        #1 rst = 1'b0;
        repeat (4) @(negedge clock);
        check("reset_outputs", {18'h0, data_parallel, rx_valid, parity_error, stop_error,
                                rx_active, rx_done, 1'b0}, 32'h0);
        rst = 1'b1;
        idle_bits(2);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("8n1_a5", 8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // 7E2 0x55, good and bad parity
        send_frame(8'h55, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        check_frame("7e2_good", 8'h55, 1'b0, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        idle_bits(2);
        send_frame(8'h55, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        check_frame("7e2_bad", 8'h55, 1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_bits(2);

        // 8O1 0x00 parity 1, stop bit low
        send_frame(8'h00, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1);
        check_frame("8o1_stoperr", 8'h00, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1);
        idle_bits(2);

        // Known data before the false start
        send_frame(8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("pre_glitch", 8'h3C, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // False start: 4-tick low glitch
        data_tx = 1'b0;
        repeat (6) @(negedge clock);
        check("false_start_active", {31'h0, rx_active}, 32'h1);
        repeat (4 * TDIV - 6) @(negedge clock);
        idle_bits(1);
        check("false_start_idle", {31'h0, rx_active}, 32'h0);
        check("false_start_pulses", pulse_cnt, exp_frames);
        check("false_start_data", {24'h0, data_parallel}, {24'h0, last_data});
        idle_bits(1);

        // Reset in the middle of data bit 3
        data_length = 1'b1;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        data_tx = 1'b0;
        repeat (BITCLK / 2) @(negedge clock);
        check("midframe_active", {31'h0, rx_active}, 32'h1);
        #2 rst = 1'b0;
        #1 check("midframe_reset", {18'h0, data_parallel, rx_valid, parity_error, stop_error,
                                    rx_active, rx_done, 1'b0}, 32'h0);
        data_tx = 1'b1;
        repeat (3) @(negedge clock);
        rst = 1'b1;
        idle_bits(12);
        check("midframe_no_valid", pulse_cnt, exp_frames);
        send_frame(8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("after_reset_5a", 8'h5A, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // Back-to-back 8N1 frames with no idle gap
        send_frame(8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("b2b_11", 8'h11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check_frame("b2b_22", 8'h22, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // Line break: one frame with stop error, then wait for line high
        data_length = 1'b1;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        data_tx     = 1'b0;
        repeat (14 * BITCLK) @(negedge clock);
        check_frame("break", 8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("break_no_rearm", pulse_cnt, exp_frames);
        check("break_inactive", {31'h0, rx_active}, 32'h0);
        idle_bits(2);
        check("break_release", pulse_cnt, exp_frames);

`ifdef UART_RX_MAJORITY_EN
        // One-tick glitch at the centre of data bit 2 is voted out
        data_length = 1'b1;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        d = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                data_tx = d[i];
                repeat (BITCLK / 2 - 1) @(negedge clock);
                data_tx = ~d[i];
                repeat (TDIV) @(negedge clock);
                data_tx = d[i];
                repeat (BITCLK / 2 + 1 - TDIV) @(negedge clock);
            end else begin
                send_bit(d[i]);
            end
        end
        send_bit(1'b1);
        check_frame("majority_glitch", d, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
`endif

        // Randomized frames
        for (int k = 0; k < 24; k++) begin
            r    = $urandom;
            d    = r[7:0];
            len8 = r[8];
            pt   = r[10:9];
            st2  = r[11];
            corr = (pt == 2'b10) ? ^(len8 ? d : (d & 8'h7F)) : ~^(len8 ? d : (d & 8'h7F));
            pb   = (r[13:12] == 2'b00) ? ~corr : corr;
            s0   = (r[16:14] != 3'd0);
            s1   = (r[19:17] != 3'd0);
            send_frame(d, len8, pt, st2, pb, s0, s1);
            check_frame("random", d, len8, pt, pb, st2, s0, s1);
            idle_bits(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- Serial-in/parallel-out receiver for the UART link. It consumes the serial line driven by the TX shifter's data_out and recovers the parallel data word, with parity and stop-bit checking.
- Uses the same frame options as the TX side: parity_type, stop_bits and data_length.
- Runs on the system clock. A 16x-baud sample_tick enable from the baud generator paces it.

Parameters:
- OVERSAMPLE, 16, sample_tick pulses per bit period; must be even and >= 8.
- SYNC_STAGES, 2, flip-flop stages in the serial-input synchronizer; must be >= 2.

Ports:
- clock  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- sample_tick  input  1  one-clock enable pulse at OVERSAMPLE x baud rate.
- data_tx  input  1  serial line, idle high.
- parity_type  input  2  00/11 = no parity, 01 = odd, 10 = even.
- stop_bits  input  1  0 = one stop bit, 1 = two stop bits.
- data_length  input  1  0 = 7 data bits, 1 = 8 data bits.
- data_parallel  output  8  received word, LSB first on the line; bit 7 is forced to 0 in 7-bit mode.
- rx_valid  output  1  one-clock pulse when data_parallel and the error flags update.
- parity_error  output  1  parity mismatch on the last frame.
- stop_error  output  1  a stop bit sampled low on the last frame.
- rx_active  output  1  high from start-bit detect until frame end.
- rx_done  output  1  high after a complete frame; cleared at the next start detect.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - data_parallel = 0; rx_valid, parity_error, stop_error, rx_active, rx_done = 0.
  - Synchronizer flops = 1.
  - Tick counter and bit counter = 0.
  - Reset mid-frame aborts the frame; no rx_valid is produced.
- Input: data_tx passes through SYNC_STAGES flops. The FSM uses only the synchronized value rx_s.
- Configuration: parity_type, stop_bits and data_length are latched at start detect and held for the whole frame.
- Tick counter advances only on clocks where sample_tick = 1. The "mid-sample" point of a bit is tick OVERSAMPLE/2 - 1 within that bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE: rx_s = 0 -> START. Counters cleared, rx_active = 1, rx_done = 0.
  - START, at mid-sample:
    - rx_s = 1 -> false start. Return to IDLE, rx_active = 0, no flags change.
    - rx_s = 0 -> DATA. Tick counter restarts, so later samples fall at bit centres, OVERSAMPLE ticks apart.
  - DATA: every OVERSAMPLE ticks, sample one bit into the shift register, LSB first. After 7 or 8 bits (per data_length):
    - go to PARITY if parity_type is 01 or 10;
    - otherwise go to STOP.
  - PARITY: sample one bit. parity_error_next = 1 when:
    - even parity: XOR of data bits and parity bit != 0;
    - odd parity: that XOR != 1.
  - STOP: sample 1 or 2 stop bits. stop_error_next = 1 if any stop sample = 0. No early exit: all stop bits are always sampled.
  - DONE (one clock):
    - data_parallel <= assembled word.
    - parity_error and stop_error <= their next values. With no parity, parity_error = 0.
    - rx_valid = 1 for this single clock; rx_done = 1; rx_active = 0.
    - Next state = IDLE.
- Latency: rx_valid asserts on the clock edge after the final stop-bit mid-sample.
- Outputs hold their values until the next DONE or reset. rx_valid never lasts longer than one clock.
- Back-to-back frames: a new start bit is detected in IDLE on the clock right after DONE. The second half of the last stop bit is therefore tolerated without loss.
- If sample_tick and a line transition coincide in IDLE, start detect occurs; tick counting begins from the next sample_tick.
- A sample_tick with rx_s = 0 held continuously (line break) yields a frame with stop_error = 1, data = 0. The FSM then waits in IDLE for rx_s = 1 before re-arming. Fall-detect requires a prior rx_s = 1.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the 2-of-3 majority of the samples at mid-sample-1, mid-sample and mid-sample+1. Start validation uses the same vote.
- Undefined: a single sample at the mid-sample tick is used.
- All timing and outputs are otherwise identical.

Test Plan:
- Reset mid-frame: drive rst low at DATA bit 3 -> all outputs 0 immediately (asynchronously), state IDLE, no rx_valid afterwards. A following clean frame 0x5A is received correctly.
- 8N1 receive: data_length=1, parity_type=00, stop_bits=0; send 0xA5 -> exactly one rx_valid pulse, data_parallel=0xA5, parity_error=0, stop_error=0, rx_done=1, rx_active=0.
- 7E2 receive: data_length=0, parity_type=10, stop_bits=1; send 0x55 with parity 0 -> data_parallel=0x55, no errors. Repeat with parity bit 1 -> parity_error=1.
- 8O1 receive and stop-bit error: send 0x00 with parity 1 but stop bit 0 -> data_parallel=0x00, parity_error=0, stop_error=1.
- False start: 4-tick low glitch in IDLE -> returns to IDLE, rx_active drops, no rx_valid, and data_parallel is unchanged.
- Back-to-back frames: 0x11 then 0x22 (8N1, no idle gap) -> two rx_valid pulses with data 0x11 then 0x22. With UART_RX_MAJORITY_EN, a single-tick glitch at mid-sample does not corrupt the bit.
